// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : i2c_pkg                                                     |
// | Brief  : Shared types and helpers for the I2C port-expander master.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    START = 4'd1,
    ADDR  = 4'd2,
    ACK1  = 4'd3,
    WDATA = 4'd4,
    RDATA = 4'd5,
    ACK2  = 4'd6,
    STOP  = 4'd7,
    DONE  = 4'd8
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int SLOTS_FULL      = 20;
  localparam int SLOTS_ADDR_NACK = 11;

  // Pad drive {scl_oe, sda_oe} for a given state, quarter and outgoing bit.
  function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] q,
                                           input logic tx_bit);
    logic scl_low;
    logic sda_low;
    scl_low = 1'b0;
    sda_low = 1'b0;
    case (st)
      START: sda_low = (q == Q2) || (q == Q3);
      ADDR, WDATA: begin
        scl_low = (q == Q0) || (q == Q1);
        sda_low = ~tx_bit;
      end
      ACK1, RDATA, ACK2: scl_low = (q == Q0) || (q == Q1);
      STOP: begin
        scl_low = (q == Q0) || (q == Q1);
        sda_low = (q != Q3);
      end
      default: begin
        scl_low = 1'b0;
        sda_low = 1'b0;
      end
    endcase
    return {scl_low, sda_low};
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_quarter_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : i2c_quarter_tick                                            |
// | Brief  : CLK_DIV prescaler producing a quarter-period tick and the   |
// |          2-bit quarter index of the current bus slot.                |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module i2c_quarter_tick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic       en,
  input  logic       restart,
  output logic       qtick,
  output logic [1:0] quarter
);

  localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    quarter_q, quarter_d;

  assign qtick   = en & ~restart & (cnt_q == CNT_MAX);
  assign quarter = quarter_q;

  // Count sclk cycles inside a quarter; restart wins over enable.
  always_comb begin
    cnt_d     = cnt_q;
    quarter_d = quarter_q;
    if (restart) begin
      cnt_d     = '0;
      quarter_d = Q0;
    end else if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d     = '0;
        quarter_d = quarter_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Prescaler and quarter registers.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      quarter_q <= Q0;
    end else begin
      cnt_q     <= cnt_d;
      quarter_q <= quarter_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_gpio_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : i2c_gpio_master                                             |
// | Brief  : Single-byte I2C initiator for an 8-bit port expander:       |
// |          START, addr+R/W, ACK, data, ACK/NACK, STOP per command.     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module i2c_gpio_master
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h00,
  parameter int         CLK_DIV    = 4
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rd_q, rd_d;
  logic       read_q, read_d;
  logic       nack_q, nack_d;
  logic       scl_oe_q, scl_oe_d;
  logic       sda_oe_q, sda_oe_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_nack_q, rsp_nack_d;
  logic       busy_q, busy_d;
  logic       cmd_ready_q, cmd_ready_d;

  logic       accept;
  logic       qtick;
  logic [1:0] quarter;
  logic [1:0] quarter_nxt;
  logic       slot_end;
  logic       sample;

  assign accept   = cmd_valid & cmd_ready_q;
  assign slot_end = qtick & (quarter == Q3);
  assign sample   = qtick & (quarter == Q2);

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_qtick (
    .sclk    (sclk),
    .reset   (reset),
    .en      (state_q != IDLE),
    .restart (accept),
    .qtick   (qtick),
    .quarter (quarter)
  );

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_nack  = rsp_nack_q;
  assign busy      = busy_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

  // Next-state and datapath; pad drives are derived from the next state so
  // they register in step with the state itself.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    rd_d        = rd_q;
    read_d      = read_q;
    nack_d      = nack_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_nack_d  = rsp_nack_q;

    if (accept)      quarter_nxt = Q0;
    else if (qtick)  quarter_nxt = quarter + 2'd1;
    else             quarter_nxt = quarter;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shreg_d   = {SLAVE_ADDR, cmd_read};
          data_d    = cmd_data;
          read_d    = cmd_read;
          nack_d    = 1'b0;
          rd_d      = 8'h00;
          bit_cnt_d = 3'd0;
        end
      end
      START: if (slot_end) state_d = ADDR;
      ADDR, WDATA: begin
        if (slot_end) begin
          shreg_d   = {shreg_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = (state_q == ADDR) ? ACK1 : ACK2;
        end
      end
      ACK1: begin
        if (sample) nack_d = sda_in;
        if (slot_end) begin
          shreg_d = data_q;
          if (nack_q)      state_d = STOP;
          else if (read_q) state_d = RDATA;
          else             state_d = WDATA;
        end
      end
      RDATA: begin
        if (sample) rd_d = {rd_q[6:0], sda_in};
        if (slot_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ACK2;
        end
      end
      ACK2: begin
        // On reads the master itself NACKs, so the line is not sampled.
        if (sample && !read_q) nack_d = sda_in;
        if (slot_end) state_d = STOP;
      end
      STOP: begin
        if (slot_end) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = (read_q && !nack_q) ? rd_q : 8'h00;
          rsp_nack_d  = nack_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    {scl_oe_d, sda_oe_d} = bus_drive(state_d, quarter_nxt, shreg_d[7]);
    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);
  end

  // Transaction FSM, datapath and registered outputs; reset releases the bus.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= 8'h00;
      data_q      <= 8'h00;
      rd_q        <= 8'h00;
      read_q      <= 1'b0;
      nack_q      <= 1'b0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_nack_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      rd_q        <= rd_d;
      read_q      <= read_d;
      nack_q      <= nack_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_nack_q  <= rsp_nack_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_gpio_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_i2c_gpio_master                                          |
// | Brief  : Self-checking bench for i2c_gpio_master with a behavioural  |
// |          expander slave, slot-level bus model and protocol monitor.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_i2c_gpio_master;

  localparam int         CLK_DIV    = 4;
  localparam logic [6:0] SLAVE_ADDR = 7'h00;
  localparam int         SLOT       = 4 * CLK_DIV;

  localparam int K_START = 0;
  localparam int K_BIT   = 1;
  localparam int K_REL   = 2;
  localparam int K_STOP  = 3;

  logic       sclk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_read;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       busy;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;

  logic       slave_pull = 1'b0;
  logic [6:0] slave_addr = 7'h00;
  logic [7:0] slave_byte = 8'h3C;
  logic       slave_ack_data = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  assign sda_in = ~(sda_oe | slave_pull);

  always #5 sclk = ~sclk;

  i2c_gpio_master #(
    .SLAVE_ADDR (SLAVE_ADDR),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .sclk      (sclk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_read  (cmd_read),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_nack  (rsp_nack),
    .busy      (busy),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .sda_in    (sda_in)
  );

  // Behavioural expander slave plus bus protocol monitor, on resolved lines.
  logic       scl_prev = 1'b1;
  logic       sda_prev = 1'b1;
  int         run_len = 0;
  bit         run_edge = 1'b0;
  int         starts = 0;
  int         stops = 0;
  int         bad_phase = 0;
  int         bitno = 0;
  logic [7:0] addr_rx = 8'h00;
  logic [7:0] data_rx = 8'h00;
  logic       ack1_rx = 1'b0;
  logic       ack2_rx = 1'b0;

  always @(negedge sclk) begin
    logic scl_now;
    logic sda_now;
    logic match;
    int   nxt;
    scl_now = ~scl_oe;
    sda_now = sda_in;
    if (reset) begin
      slave_pull = 1'b0;
      bitno      = 0;
      run_edge   = 1'b0;
    end else begin
      if (sda_now != sda_prev && scl_now && scl_prev) begin
        if (!sda_now) begin
          starts++;
          bitno = 0;
        end else begin
          stops++;
        end
      end
      if (scl_now != scl_prev) begin
        if (run_edge && run_len != 2 * CLK_DIV) bad_phase++;
        run_edge = busy;
        run_len  = 1;
        if (scl_now) begin
          bitno++;
          if (bitno >= 1 && bitno <= 8)        addr_rx = {addr_rx[6:0], sda_now};
          else if (bitno == 9)                 ack1_rx = sda_now;
          else if (bitno >= 10 && bitno <= 17) data_rx = {data_rx[6:0], sda_now};
          else if (bitno == 18)                ack2_rx = sda_now;
        end else begin
          nxt   = bitno + 1;
          match = (addr_rx[7:1] == slave_addr);
          if (nxt == 9)                   slave_pull = match;
          else if (nxt >= 10 && nxt <= 17) slave_pull = match & addr_rx[0] & ~slave_byte[17 - nxt];
          else if (nxt == 18)             slave_pull = match & ~addr_rx[0] & slave_ack_data;
          else                            slave_pull = 1'b0;
        end
      end else begin
        run_len++;
      end
      if (!busy) run_edge = 1'b0;
    end
    scl_prev = scl_now;
    sda_prev = sda_now;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One command: builds the slot list of the expected bus transaction and
  // checks every cycle from accept to the first idle cycle after DONE.
  task automatic txn(input logic rd, input logic [7:0] data, input int exp_lat,
                     input bit hold, input int pulse_k, input int abort_k);
    int         kind [20];
    logic       bitv [20];
    int         ns, nlast, lat, s, q, st0, sp0, bp0;
    logic [7:0] abyte, exp_rsp, held_data;
    logic       addr_ack, exp_nack, e_scl, e_sda, held_nack;

    abyte    = {SLAVE_ADDR, rd};
    addr_ack = (slave_addr == SLAVE_ADDR);
    ns = 0;
    kind[ns] = K_START; bitv[ns] = 1'b0; ns++;
    for (int i = 7; i >= 0; i--) begin kind[ns] = K_BIT; bitv[ns] = abyte[i]; ns++; end
    kind[ns] = K_REL; bitv[ns] = 1'b0; ns++;
    if (addr_ack) begin
      for (int i = 7; i >= 0; i--) begin
        kind[ns] = rd ? K_REL : K_BIT;
        bitv[ns] = data[i];
        ns++;
      end
      kind[ns] = K_REL; bitv[ns] = 1'b0; ns++;
    end
    kind[ns] = K_STOP; bitv[ns] = 1'b0; ns++;
    exp_nack = !addr_ack || (!rd && !slave_ack_data);
    exp_rsp  = (rd && addr_ack) ? slave_byte : 8'h00;
    nlast    = ns * SLOT + 1;

    st0 = starts; sp0 = stops; bp0 = bad_phase;
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_data  = data;
    chk("cmd_ready_before_accept", cmd_ready, 1);
    @(posedge sclk);
    #1;
    if (!hold) cmd_valid = 1'b0;

    lat = 0;
    for (int k = 1; k <= nlast; k++) begin
      @(negedge sclk);
      if (k < nlast) begin
        s = (k - 1) / SLOT;
        q = ((k - 1) / CLK_DIV) % 4;
        case (kind[s])
          K_START: begin e_scl = 1'b0;  e_sda = (q >= 2);   end
          K_BIT:   begin e_scl = (q < 2); e_sda = ~bitv[s]; end
          K_REL:   begin e_scl = (q < 2); e_sda = 1'b0;     end
          default: begin e_scl = (q < 2); e_sda = (q < 3);  end
        endcase
        chk("scl_oe", scl_oe, e_scl);
        chk("sda_oe", sda_oe, e_sda);
        chk("busy_in_txn", busy, 1);
        chk("cmd_ready_in_txn", cmd_ready, 0);
        chk("rsp_valid_early", rsp_valid, 0);
      end else begin
        chk("rsp_valid_done", rsp_valid, 1);
        chk("busy_done", busy, 1);
        chk("cmd_ready_done", cmd_ready, 0);
        chk("rsp_data", rsp_data, exp_rsp);
        chk("rsp_nack", rsp_nack, exp_nack);
        chk("scl_oe_done", scl_oe, 0);
        chk("sda_oe_done", sda_oe, 0);
      end
      if (rsp_valid && lat == 0) lat = k;
      if (pulse_k > 0 && k == pulse_k) begin
        cmd_valid = 1'b1;
        cmd_read  = ~rd;
        cmd_data  = ~data;
      end
      if (pulse_k > 0 && k == pulse_k + 1) cmd_valid = 1'b0;
      if (abort_k > 0 && k == abort_k) begin
        #2;
        reset = 1'b1;
        #1;
        chk("scl_oe_async_reset", scl_oe, 0);
        chk("sda_oe_async_reset", sda_oe, 0);
        return;
      end
    end

    chk("latency", lat, exp_lat);
    chk("start_count", starts - st0, 1);
    chk("stop_count", stops - sp0, 1);
    chk("scl_phase_len", bad_phase - bp0, 0);

    held_data = rsp_data;
    held_nack = rsp_nack;
    @(negedge sclk);
    chk("cmd_ready_idle", cmd_ready, 1);
    chk("busy_idle", busy, 0);
    chk("rsp_valid_pulse", rsp_valid, 0);
    chk("rsp_data_hold", rsp_data, held_data);
    chk("rsp_nack_hold", rsp_nack, held_nack);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_read  = 1'b0;
    cmd_data  = 8'h00;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_rsp_nack", rsp_nack, 0);
    reset = 1'b0;
    repeat (3) @(negedge sclk);
    chk("idle_busy", busy, 0);

    // Write 0xA5, everything ACKed.
    txn(1'b0, 8'hA5, 321, 1'b0, 0, 0);
    chk("wr_addr_byte", addr_rx, 8'h00);
    chk("wr_data_byte", data_rx, 8'hA5);
    chk("wr_ack2_low", ack2_rx, 0);
    chk("wr_rise_count", bitno, 19);

    // Read, slave returns 0x3C; master NACKs the data byte.
    slave_byte = 8'h3C;
    txn(1'b1, 8'hEE, 321, 1'b0, 0, 0);
    chk("rd_addr_byte", addr_rx, 8'h01);
    chk("rd_master_nack", ack2_rx, 1);
    chk("rd_rsp_data_lit", rsp_data, 8'h3C);
    chk("rd_rsp_nack_lit", rsp_nack, 0);

    // Address NACK: slave answers a different address.
    slave_addr = 7'h12;
    txn(1'b0, 8'h77, 177, 1'b0, 0, 0);
    chk("an_rise_count", bitno, 10);
    chk("an_rsp_nack_lit", rsp_nack, 1);
    chk("an_rsp_data_lit", rsp_data, 8'h00);
    slave_addr = 7'h00;

    // Write whose data byte the slave NACKs.
    slave_ack_data = 1'b0;
    txn(1'b0, 8'hC3, 321, 1'b0, 0, 0);
    chk("dn_rsp_nack_lit", rsp_nack, 1);
    slave_ack_data = 1'b1;

    // Reset in the middle of WDATA (slot 12, q0: SCL and SDA both pulled).
    txn(1'b0, 8'h96, 0, 1'b0, 0, 193);
    repeat (2) @(negedge sclk);
    reset = 1'b0;
    @(negedge sclk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_scl_oe", scl_oe, 0);
    chk("post_rst_sda_oe", sda_oe, 0);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    txn(1'b0, 8'h5A, 321, 1'b0, 0, 0);
    chk("after_rst_data_byte", data_rx, 8'h5A);

    // Back-to-back with cmd_valid held high across DONE.
    slave_byte = 8'h81;
    txn(1'b0, 8'h11, 321, 1'b1, 0, 0);
    txn(1'b1, 8'h00, 321, 1'b0, 0, 0);
    chk("b2b_rd_data_lit", rsp_data, 8'h81);

    // cmd_valid pulsed while busy must be ignored.
    txn(1'b0, 8'h3C, 321, 1'b0, 100, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge sclk);
      chk("no_extra_busy", busy, 0);
      chk("no_extra_scl", scl_oe, 0);
      chk("no_extra_sda", sda_oe, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
